fetch_unit: RTL

Instruction-fetch front end of the pipelined RV32I core: it owns the PC register and consumes the `PCSrc` redirect produced by the control/branch logic in Execute. It issues word requests to instruction memory over a valid/ready handshake, with at most one request outstanding. It drives the IF/ID pipeline register (`InstrD`, `PCD`, `PCPlus4D`, `ValidD`) under hazard-unit stall/flush control, so the decoder always receives right-path instructions or explicit bubbles.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 34 +++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package pipeline_pkg;

   typedef enum logic [1:0] {
      PCSRC_SEQ    = 2'b00,
      PCSRC_BRANCH = 2'b01,
      PCSRC_JALR   = 2'b11
   } pcsrc_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction that returns while decode is stalled.
module fetch_skid_buffer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  clear,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] instr_in,
   input  logic [DATA_WIDTH-1:0] pc_in,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full  <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else begin
         if (clear || pop)
            full <= 1'b0;
         else if (load)
            full <= 1'b1;
         if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, single-outstanding imem requests,
// skid buffer and IF/ID pipeline register under hazard stall/flush control.
//
// state | meaning
// IDLE  | nothing outstanding
// WAIT  | one right-path request outstanding
// DROP  | one wrong-path request outstanding, its response is discarded
module fetch_unit
   import pipeline_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            PCSrc,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   input  logic [DATA_WIDTH-1:0] ALUResultE,
   input  logic                  StallF,
   input  logic                  StallD,
   input  logic                  FlushD,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D,
   output logic                  ValidD
);

   localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);
   localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

   pcsrc_e                pcsrc;
   fetch_state_e          state, state_nxt;
   logic                  redirect;
   logic [DATA_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] pcf, pc_pend;
   logic                  accept, resp_ok, skid_fill, skid_clear, skid_pop;
   logic                  skid_full;
   logic [DATA_WIDTH-1:0] skid_instr, skid_pc;
   logic                  ifid_update;

   // Reserved encoding 2'b10 falls through as sequential.
   assign pcsrc    = pcsrc_e'(PCSrc);
   assign redirect = (pcsrc == PCSRC_BRANCH) || (pcsrc == PCSRC_JALR);
   assign target   = (pcsrc == PCSRC_JALR) ? {ALUResultE[DATA_WIDTH-1:1], 1'b0} : PCTargetE;

   assign accept    = imem_req && imem_ready;
   assign skid_fill = resp_ok && StallD;
   assign imem_addr = pcf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: begin
            if (redirect)
               state_nxt = imem_rvalid ? IDLE : DROP;
            else if (imem_rvalid)
               state_nxt = accept ? WAIT : IDLE;
         end
         DROP: if (imem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      resp_ok  = 1'b0;
      imem_req = 1'b0;
      if ((state == WAIT) && imem_rvalid && !redirect)
         resp_ok = 1'b1;
      // A new request may overlap the returning response, but never the skid.
      if (!rst && !StallF && !redirect && !skid_full && !(resp_ok && StallD) &&
          ((state == IDLE) || ((state == WAIT) && imem_rvalid)))
         imem_req = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcf     <= RESET_VECTOR;
         pc_pend <= '0;
      end else begin
         if (redirect)
            pcf <= target;
         else if (accept)
            pcf <= pcf + FOUR;
         if (accept)
            pc_pend <= pcf;
      end
   end

   assign skid_clear = redirect || (FlushD && !StallD);
   assign skid_pop   = !StallD && !FlushD && !redirect && skid_full;

   fetch_skid_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_fill),
      .clear    (skid_clear),
      .pop      (skid_pop),
      .instr_in (imem_rdata),
      .pc_in    (pc_pend),
      .full     (skid_full),
      .instr    (skid_instr),
      .pc       (skid_pc)
   );

   assign ifid_update = !StallD || FlushD || redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         InstrD   <= NOP;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (ifid_update) begin
         if (FlushD || redirect) begin
            InstrD <= NOP;
            ValidD <= 1'b0;
         end else if (skid_full) begin
            InstrD   <= skid_instr;
            PCD      <= skid_pc;
            PCPlus4D <= skid_pc + FOUR;
            ValidD   <= 1'b1;
         end else if (resp_ok) begin
            InstrD   <= imem_rdata;
            PCD      <= pc_pend;
            PCPlus4D <= pc_pend + FOUR;
            ValidD   <= 1'b1;
         end else begin
            InstrD <= NOP;
            ValidD <= 1'b0;
         end
      end
   end

endmodule
